// File: rtl/stage_mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package stage_mem_pkg;

  // Writeback source select encodings
  localparam int RF_SRC_WIDTH = 2;
  localparam logic [RF_SRC_WIDTH-1:0] RF_SRC_ALU = 2'd0;
  localparam logic [RF_SRC_WIDTH-1:0] RF_SRC_MEM = 2'd1;

  // Access sequencer states
  typedef enum logic [0:0] {
    MEM_FSM_IDLE = 1'b0,
    MEM_FSM_BUSY = 1'b1
  } mem_fsm_e;

  // EX/MEM pipeline register contents; all-zero is a bubble
  typedef struct packed {
    logic [31:0]             result;
    logic                    mem_we;
    logic [31:0]             mem_data;
    logic                    rf_we;
    logic [4:0]              rf_dst;
    logic [RF_SRC_WIDTH-1:0] rf_src;
  } pipe_reg_t;

  // Word accesses need the two low address bits clear
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: EX/MEM register, req/ack data-memory
// sequencer with timeout, sticky error flag and registered WB bundle.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [31:0]             ex_opResult,
  input  logic                    ex_memWE,
  input  logic [31:0]             ex_memData,
  input  logic                    ex_rfWE,
  input  logic [4:0]              ex_rfDst,
  input  logic [RF_SRC_WIDTH-1:0] ex_rfSrc,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack,
  output logic                    mem_stall,
  output logic                    mem_err,
  output logic                    wb_rfWE,
  output logic [4:0]              wb_rfDst,
  output logic [31:0]             wb_rfData
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);

  pipe_reg_t        r_q, r_d, ex_s;
  mem_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wb_we_q, wb_we_d;
  logic [4:0]       wb_dst_q, wb_dst_d;
  logic [31:0]      wb_data_q, wb_data_d;

  logic is_load_s, is_access_s, misaligned_s, req_s, stall_s, abort_s;

  // Classify the instruction held in the pipeline register
  always_comb begin
    is_load_s    = r_q.rf_we && (r_q.rf_src == RF_SRC_MEM);
    is_access_s  = is_load_s || r_q.mem_we;
    misaligned_s = is_access_s && is_misaligned(r_q.result[1:0]);
    // R is held for the whole access, so this stays high and stable in BUSY
    req_s        = is_access_s && !misaligned_s;
  end

  // Access sequencer: stall, abort, next state and timeout counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_s = 1'b0;
    abort_s = 1'b0;
    case (state_q)
      MEM_FSM_IDLE: begin
        if (req_s && !mem_ack) begin
          stall_s = 1'b1;
          state_d = MEM_FSM_BUSY;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = MEM_FSM_IDLE;
        end
      end
      MEM_FSM_BUSY: begin
        if (mem_ack) begin
          // ack wins over a coincident timeout
          state_d = MEM_FSM_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          abort_s = 1'b1;
          state_d = MEM_FSM_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          stall_s = 1'b1;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
        end
      end
      default: begin
        state_d = MEM_FSM_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Next values of the pipeline register, error flag and WB bundle
  always_comb begin
    ex_s      = {ex_opResult, ex_memWE, ex_memData, ex_rfWE, ex_rfDst, ex_rfSrc};
    r_d       = r_q;
    err_d     = err_q | misaligned_s | abort_s;
    wb_we_d   = 1'b0;
    wb_dst_d  = wb_dst_q;
    wb_data_d = wb_data_q;
    if (stall_s) begin
      // R holds (flush ignored); a bubble goes to WB
      r_d     = r_q;
      wb_we_d = 1'b0;
    end else begin
      r_d       = flush ? '0 : ex_s;
      wb_we_d   = r_q.rf_we && !abort_s && !misaligned_s;
      wb_dst_d  = r_q.rf_dst;
      wb_data_d = is_load_s ? mem_rdata : r_q.result;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q       <= '0;
      state_q   <= MEM_FSM_IDLE;
      cnt_q     <= CNT_ZERO;
      err_q     <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_dst_q  <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      r_q       <= r_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wb_we_q   <= wb_we_d;
      wb_dst_q  <= wb_dst_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign mem_req   = req_s;
  assign mem_we    = r_q.mem_we;
  assign mem_addr  = {r_q.result[31:2], 2'b00};
  assign mem_wdata = r_q.mem_data;
  assign mem_stall = stall_s;
  assign mem_err   = err_q;
  assign wb_rfWE   = wb_we_q;
  assign wb_rfDst  = wb_dst_q;
  assign wb_rfData = wb_data_q;

endmodule
